// File: rtl/alu_check_pkg.sv
// Shared types for alu_vector_checker: checker FSM state encoding and the
// ALU fn3 function codes used when building vector tables.
package alu_check_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      FN3_ADD_SUB = 3'd0,
      FN3_SLL     = 3'd1,
      FN3_SLT     = 3'd2,
      FN3_SLTU    = 3'd3,
      FN3_XOR     = 3'd4,
      FN3_SRL_SRA = 3'd5,
      FN3_OR      = 3'd6,
      FN3_AND     = 3'd7
   } fn3_e;

endpackage

// File: rtl/alu_check_vec_mem.sv
// Vector table storage for alu_vector_checker.
// DEPTH entries of WIDTH bits; one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset so a loaded table survives
// a checker reset.
//   clk       in   write clock
//   i_wr_en   in   write strobe
//   i_wr_addr in   write index
//   i_wr_data in   entry to write
//   i_rd_addr in   read index
//   o_rd_data out  entry at i_rd_addr (combinational)
module alu_check_vec_mem #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read port
   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_vector_checker.sv
// Self-checking stimulus engine for an ALU (or a pipelined ALU wrapper).
// A loadable table of {a, b, fn3, fn7_bit5, expect} vectors is issued one per
// enabled cycle on alu_*; each DUT result is compared DUT_LAT+1 enabled edges
// after its operands were issued. Reports pass, fail count and the first
// failing vector.
//
// Optional build macro ALU_CHECK_STOP_ON_FAIL_EN: the first mismatch ends the
// run (issue stops, pending compares are dropped, DONE follows on the next
// enabled edge). Without it every vector is run and all mismatches counted.
//
// Ports:
//   clk, async_rst_n         clock, asynchronous active-low reset
//   clk_en                   global advance enable (low freezes all state)
//   start, num_vec           begin a run of num_vec vectors (clamped to DEPTH)
//   ld_en, ld_addr, ld_*     table write, accepted only in IDLE/DONE
//   alu_a/b/fn3/fn7_bit5     registered operands to the DUT
//   alu_result               DUT result
//   busy, done, pass         run status (pass valid while done)
//   fail_cnt                 mismatches this run
//   first_fail_idx/got       index and DUT result of the first mismatch
module alu_vector_checker
   import alu_check_pkg::*;
#(
   parameter  int unsigned XLEN    = 32,
   parameter  int unsigned DEPTH   = 16,
   parameter  int unsigned DUT_LAT = 0,
   localparam int unsigned IW      = $clog2(DEPTH),
   localparam int unsigned CW      = IW + 1
) (
   input  logic            clk,
   input  logic            async_rst_n,
   input  logic            clk_en,
   input  logic            start,
   input  logic [CW-1:0]   num_vec,
   input  logic            ld_en,
   input  logic [IW-1:0]   ld_addr,
   input  logic [XLEN-1:0] ld_a,
   input  logic [XLEN-1:0] ld_b,
   input  logic [XLEN-1:0] ld_expect,
   input  logic [2:0]      ld_fn3,
   input  logic            ld_fn7_bit5,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_fn3,
   output logic            alu_fn7_bit5,
   input  logic [XLEN-1:0] alu_result,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [CW-1:0]   fail_cnt,
   output logic [IW-1:0]   first_fail_idx,
   output logic [XLEN-1:0] first_fail_got
);

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp_val;
      logic [2:0]      fn3;
      logic            fn7_bit5;
   } vec_t;

   localparam int unsigned VW = $bits(vec_t);
   localparam int unsigned PD = DUT_LAT + 1;

   state_e          r_state;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   r_last;
   logic [PD-1:0]   r_cp_vld;
   logic [IW-1:0]   r_cp_idx [PD];
   logic [XLEN-1:0] r_cp_exp [PD];

   logic [XLEN-1:0] r_alu_a;
   logic [XLEN-1:0] r_alu_b;
   logic [2:0]      r_alu_fn3;
   logic            r_alu_fn7_bit5;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [CW-1:0]   r_fail_cnt;
   logic [IW-1:0]   r_ff_idx;
   logic [XLEN-1:0] r_ff_got;

   vec_t            w_wr_vec;
   vec_t            w_rd_vec;
   logic [VW-1:0]   w_rd_bits;
   logic [IW-1:0]   w_rd_addr;
   logic            w_idle_like;
   logic            w_wr_en;
   logic [CW-1:0]   w_num_clamp;
   logic            w_mismatch;
   logic            w_stop;

   // Table write payload
   always_comb begin
      w_wr_vec          = '0;
      w_wr_vec.a        = ld_a;
      w_wr_vec.b        = ld_b;
      w_wr_vec.exp_val  = ld_expect;
      w_wr_vec.fn3      = ld_fn3;
      w_wr_vec.fn7_bit5 = ld_fn7_bit5;
   end

   assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
   assign w_wr_en     = clk_en && ld_en && w_idle_like;

   // Start issues entry 0; during RUN the issue index addresses the table
   assign w_rd_addr = (r_state == RUN) ? r_idx : '0;

   alu_check_vec_mem #(
      .WIDTH (VW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (ld_addr),
      .i_wr_data (w_wr_vec),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_bits)
   );

   assign w_rd_vec    = vec_t'(w_rd_bits);
   assign w_num_clamp = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
   assign w_mismatch  = r_cp_vld[PD-1] && (alu_result != r_cp_exp[PD-1]);

`ifdef ALU_CHECK_STOP_ON_FAIL_EN
   assign w_stop = w_mismatch;
`else
   assign w_stop = 1'b0;
`endif

   // Checker FSM, compare pipeline and result registers
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_state        <= IDLE;
         r_idx          <= '0;
         r_last         <= '0;
         r_cp_vld       <= '0;
         for (int unsigned i = 0; i < PD; i++) begin
            r_cp_idx[i] <= '0;
            r_cp_exp[i] <= '0;
         end
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_alu_fn3      <= '0;
         r_alu_fn7_bit5 <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_pass         <= 1'b0;
         r_fail_cnt     <= '0;
         r_ff_idx       <= '0;
         r_ff_got       <= '0;
      end else if (clk_en) begin
         // Compare pipeline shifts every enabled edge; slot 0 fills only on issue
         r_cp_vld[0] <= 1'b0;
         for (int unsigned i = 1; i < PD; i++) begin
            r_cp_vld[i] <= r_cp_vld[i-1];
            r_cp_idx[i] <= r_cp_idx[i-1];
            r_cp_exp[i] <= r_cp_exp[i-1];
         end

         if (w_mismatch) begin
            r_fail_cnt <= r_fail_cnt + CW'(1);
            if (r_fail_cnt == '0) begin
               r_ff_idx <= r_cp_idx[PD-1];
               r_ff_got <= alu_result;
            end
         end

         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_fail_cnt <= '0;
                  r_ff_idx   <= '0;
                  r_ff_got   <= '0;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
                  if (w_num_clamp == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else begin
                     // The start edge itself issues vector 0
                     r_alu_a        <= w_rd_vec.a;
                     r_alu_b        <= w_rd_vec.b;
                     r_alu_fn3      <= w_rd_vec.fn3;
                     r_alu_fn7_bit5 <= w_rd_vec.fn7_bit5;
                     r_cp_vld[0]    <= 1'b1;
                     r_cp_idx[0]    <= '0;
                     r_cp_exp[0]    <= w_rd_vec.exp_val;
                     r_busy         <= 1'b1;
                     r_last         <= IW'(w_num_clamp - CW'(1));
                     r_idx          <= IW'(1);
                     r_state        <= (w_num_clamp == CW'(1)) ? DRAIN : RUN;
                  end
               end
            end

            RUN: begin
               if (w_stop) begin
                  r_cp_vld <= '0;
                  r_state  <= DRAIN;
               end else begin
                  r_alu_a        <= w_rd_vec.a;
                  r_alu_b        <= w_rd_vec.b;
                  r_alu_fn3      <= w_rd_vec.fn3;
                  r_alu_fn7_bit5 <= w_rd_vec.fn7_bit5;
                  r_cp_vld[0]    <= 1'b1;
                  r_cp_idx[0]    <= r_idx;
                  r_cp_exp[0]    <= w_rd_vec.exp_val;
                  if (r_idx == r_last) begin
                     r_state <= DRAIN;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end
            end

            DRAIN: begin
               // alu_* hold; finish once no compare is outstanding
               if (w_stop) begin
                  r_cp_vld <= '0;
               end else if (r_cp_vld == '0) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_fail_cnt == '0);
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign alu_a          = r_alu_a;
   assign alu_b          = r_alu_b;
   assign alu_fn3        = r_alu_fn3;
   assign alu_fn7_bit5   = r_alu_fn7_bit5;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign fail_cnt       = r_fail_cnt;
   assign first_fail_idx = r_ff_idx;
   assign first_fail_got = r_ff_got;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: two checkers share one stimulus stream, one
// driving a combinational ALU model (DUT_LAT=0) and one a two-stage
// clk_en-gated ALU model (DUT_LAT=2). Expected run results are queued at
// start and popped by a monitor when each checker reports done.
module tb_alu_vector_checker;
   import alu_check_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned IW    = 4;
   localparam int unsigned CW    = 5;

   typedef struct {
      logic            pass;
      logic [CW-1:0]   cnt;
      logic [IW-1:0]   idx;
      logic [XLEN-1:0] got;
      int              cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            async_rst_n = 1'b1;
   logic            clk_en = 1'b1;
   logic            start = 1'b0;
   logic [CW-1:0]   num_vec = '0;
   logic            ld_en = 1'b0;
   logic [IW-1:0]   ld_addr = '0;
   logic [XLEN-1:0] ld_a = '0, ld_b = '0, ld_expect = '0;
   logic [2:0]      ld_fn3 = '0;
   logic            ld_fn7_bit5 = 1'b0;

   logic [XLEN-1:0] a0, b0, res0, ffg0, a2, b2, res2, ffg2, p1, p2;
   logic [2:0]      f30, f32;
   logic            f70, f72, busy0, busy2, done0, done2, pass0, pass2;
   logic [CW-1:0]   fc0, fc2;
   logic [IW-1:0]   ffi0, ffi2;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic st_edge = 1'b0;
   logic pd0 = 1'b0, pd2 = 1'b0;
   exp_t q0[$], q2[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic f7);
      case (f3)
         FN3_ADD_SUB: return f7 ? a - b : a + b;
         FN3_SLL:     return a << b[4:0];
         FN3_SLT:     return {31'd0, $signed(a) < $signed(b)};
         FN3_SLTU:    return {31'd0, a < b};
         FN3_XOR:     return a ^ b;
         FN3_SRL_SRA: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         FN3_OR:      return a | b;
         default:     return a & b;
      endcase
   endfunction

   assign res0 = alu_f(a0, b0, f30, f70);

   always @(posedge clk) begin
      if (clk_en) begin
         p1 <= alu_f(a2, b2, f32, f72);
         p2 <= p1;
      end
   end
   assign res2 = p2;

   alu_vector_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .DUT_LAT(0)) u_dut0 (
      .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .start(start),
      .num_vec(num_vec), .ld_en(ld_en), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
      .ld_expect(ld_expect), .ld_fn3(ld_fn3), .ld_fn7_bit5(ld_fn7_bit5),
      .alu_a(a0), .alu_b(b0), .alu_fn3(f30), .alu_fn7_bit5(f70), .alu_result(res0),
      .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fc0),
      .first_fail_idx(ffi0), .first_fail_got(ffg0));

   alu_vector_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .DUT_LAT(2)) u_dut2 (
      .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .start(start),
      .num_vec(num_vec), .ld_en(ld_en), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
      .ld_expect(ld_expect), .ld_fn3(ld_fn3), .ld_fn7_bit5(ld_fn7_bit5),
      .alu_a(a2), .alu_b(b2), .alu_fn3(f32), .alu_fn7_bit5(f72), .alu_result(res2),
      .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fc2),
      .first_fail_idx(ffi2), .first_fail_got(ffg2));

   // Edge counter and "start was accepted at the last edge" flag
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      st_edge <= start && clk_en && async_rst_n;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_res(input string nm, input exp_t e, input logic ps, input logic bz,
                            input logic [CW-1:0] fc, input logic [IW-1:0] fi,
                            input logic [XLEN-1:0] fg);
      chk({nm, " pass"},       64'(ps),  64'(e.pass));
      chk({nm, " busy"},       64'(bz),  64'(0));
      chk({nm, " fail_cnt"},   64'(fc),  64'(e.cnt));
      chk({nm, " first_idx"},  64'(fi),  64'(e.idx));
      chk({nm, " first_got"},  64'(fg),  64'(e.got));
      chk({nm, " done cycle"}, 64'(cyc), 64'(e.cyc));
   endtask

   // Monitor: a new done report (rising, or re-asserted by an accepted start)
   always @(negedge clk) begin
      if (async_rst_n) begin
         if (done0 && (!pd0 || st_edge)) begin
            if (q0.size() == 0) chk("lat0 unexpected done", 64'(1), 64'(0));
            else check_res("lat0", q0.pop_front(), pass0, busy0, fc0, ffi0, ffg0);
         end
         if (done2 && (!pd2 || st_edge)) begin
            if (q2.size() == 0) chk("lat2 unexpected done", 64'(1), 64'(0));
            else check_res("lat2", q2.pop_front(), pass2, busy2, fc2, ffi2, ffg2);
         end
      end
      pd0 = done0;
      pd2 = done2;
   end

   function automatic int done_cyc(input int e0, input int n, input int lat,
                                   input int ecnt, input int eidx, input int gate);
      if (n == 0) return e0;
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
      if (ecnt > 0) return e0 + eidx + lat + 2 + gate;
`else
      if (ecnt < 0) return 0;
`endif
      return e0 + n + lat + 1 + gate;
   endfunction

   task automatic load(input int idx, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      @(negedge clk);
      ld_addr = IW'(idx); ld_fn3 = f3; ld_fn7_bit5 = f7;
      ld_a = a; ld_b = b; ld_expect = e; ld_en = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // Start a run; returns 1 time unit after the start edge E0
   task automatic run(input int n, input logic ep, input int ecnt, input int eidx,
                      input logic [31:0] egot, input int gate);
      exp_t e;
      int   e0;
      @(negedge clk);
      num_vec = CW'(n); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e0 = cyc;
      e.pass = ep; e.cnt = CW'(ecnt); e.idx = IW'(eidx); e.got = egot;
      e.cyc = done_cyc(e0, n, 0, ecnt, eidx, gate);
      q0.push_back(e);
      e.cyc = done_cyc(e0, n, 2, ecnt, eidx, gate);
      q2.push_back(e);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((q0.size() != 0 || q2.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("run completion pending", 64'(q0.size() + q2.size()), 64'(0));
      q0.delete();
      q2.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stop_cnt;
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
      stop_cnt = 1;
`else
      stop_cnt = 2;
`endif
      #2 async_rst_n = 1'b0;
      #1;
      chk("rst alu_a",     64'(a0),   64'(0));
      chk("rst busy",      64'(busy0), 64'(0));
      chk("rst done",      64'(done0), 64'(0));
      chk("rst pass",      64'(pass0), 64'(0));
      chk("rst fail_cnt",  64'(fc0),  64'(0));
      chk("rst first_idx", 64'(ffi0), 64'(0));
      chk("rst first_got", 64'(ffg0), 64'(0));
      chk("rst lat2 busy", 64'(busy2), 64'(0));
      repeat (2) @(negedge clk);
      async_rst_n = 1'b1;

      // ADD / SUB, all pass
      load(0, FN3_ADD_SUB, 1'b0, 32'd10, 32'd2, 32'd12);
      load(1, FN3_ADD_SUB, 1'b1, 32'd10, 32'd2, 32'd8);
      run(2, 1'b1, 0, 0, 32'd0, 0);
      chk("E0 lat0 alu_a", 64'(a0), 64'(10));
      chk("E0 lat2 alu_a", 64'(a2), 64'(10));
      chk("E0 busy",       64'(busy0), 64'(1));
      wait_idle();

      // SRA of the sign bit across the full width
      load(0, FN3_SRL_SRA, 1'b1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
      run(1, 1'b1, 0, 0, 32'd0, 0);
      wait_idle();

      // Five vectors, idx3 carries a wrong expected value
      load(0, FN3_XOR,  1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
      load(1, FN3_OR,   1'b0, 32'd1, 32'd2, 32'd3);
      load(2, FN3_AND,  1'b0, 32'hFF, 32'h0F, 32'h0F);
      load(3, FN3_SLT,  1'b0, 32'd2, 32'hFFFF_FFFE, 32'd1);
      load(4, FN3_SLTU, 1'b0, 32'd2, 32'hFFFF_FFFE, 32'd1);
      run(5, 1'b0, 1, 3, 32'd0, 0);
      load(4, FN3_SLTU, 1'b0, 32'd2, 32'hFFFF_FFFE, 32'd0); // while busy: dropped
      wait_idle();

      // Same table with clk_en low for three edges mid-run
      run(5, 1'b0, 1, 3, 32'd0, 3);
      @(posedge clk);
      @(negedge clk);
      clk_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("gated lat0 alu_a", 64'(a0), 64'(1));
      chk("gated lat2 alu_a", 64'(a2), 64'(1));
      clk_en = 1'b1;
      wait_idle();

      // Reset mid-run clears outputs at once; table survives
      run(5, 1'b0, 1, 3, 32'd0, 0);
      @(posedge clk);
      #3 async_rst_n = 1'b0;
      #1;
      chk("midrst alu_a",  64'(a0),   64'(0));
      chk("midrst busy",   64'(busy0), 64'(0));
      chk("midrst lat2 busy", 64'(busy2), 64'(0));
      chk("midrst lat2 alu_a", 64'(a2), 64'(0));
      q0.delete();
      q2.delete();
      @(negedge clk);
      async_rst_n = 1'b1;
      run(5, 1'b0, 1, 3, 32'd0, 0);
      wait_idle();

      // Empty run
      run(0, 1'b1, 0, 0, 32'd0, 0);
      wait_idle();

      // Mismatches at idx1 and idx3
      load(0, FN3_ADD_SUB, 1'b0, 32'd1, 32'd1, 32'd2);
      load(1, FN3_SLL,     1'b0, 32'd1, 32'd4, 32'd15);
      load(2, FN3_SRL_SRA, 1'b0, 32'h100, 32'd4, 32'h10);
      load(3, FN3_ADD_SUB, 1'b1, 32'd5, 32'd7, 32'd2);
      run(4, 1'b0, stop_cnt, 1, 32'd16, 0);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
